ttl_univ_reg: RTL and testbench

Parametrised successor of the TTL D flip-flop models: a WIDTH-bit register emulating 7474/74174/74194-class parts, oversampled on the master clock mclk.
- The TTL device clock is an ordinary signal; edges are detected on mclk, with an optional deglitch filter.
- Per-bit preset/clear, plus hold/shift-right/shift-left/load modes.
- Used wherever PDP-8/I module boards chain D flip-flops into registers or shifters.

---
 rtl/ttl_univ_reg.sv | 112 +++++++++++
 tb/tb_ttl_univ_reg.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ttl_univ_reg.sv
// rtl/ttl_univ_reg.sv - WIDTH-bit TTL-style universal register oversampled on i_mclk
// Emulated device clock is deglitched and edge-detected; per-bit preset/clear override edges.
module ttl_univ_reg #(
  parameter int unsigned            WIDTH     = 4,
  parameter int unsigned            FILTER    = 0,
  parameter int unsigned            EDGE      = 1,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             i_mclk,
  input  logic             i_reset,
  input  logic             i_clk,
  input  logic [1:0]       i_s,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sr_in,
  input  logic             i_sl_in,
  input  logic [WIDTH-1:0] i_pre_n,
  input  logic [WIDTH-1:0] i_clr_n,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_n
);

  localparam int unsigned      CW       = (FILTER == 0) ? 1 : $clog2(FILTER + 1);
  localparam logic [CW-1:0]    FILT     = CW'(FILTER);
  localparam logic             EDGE_LVL = (EDGE != 0);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_n;
  logic             r_clk_f;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_d_s;
  logic [1:0]       r_s_s;
  logic             r_sr_s;
  logic             r_sl_s;

  logic             w_accept;
  logic             w_edge;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_next;

  // A transition is accepted on the FILTER+1-th consecutive differing sample.
  assign w_accept = (i_clk != r_clk_f) && (r_cnt == FILT);
  assign w_edge   = w_accept && (i_clk == EDGE_LVL);

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shr = r_sr_s;
      assign w_shl = r_sl_s;
    end else begin : g_wn
      assign w_shr = {r_q[WIDTH-2:0], r_sr_s};
      assign w_shl = {r_sl_s, r_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_next = r_q;
    case (r_s_s)
      2'b01:   w_next = w_shr;
      2'b10:   w_next = w_shl;
      2'b11:   w_next = r_d_s;
      default: w_next = r_q;
    endcase
  end

  always_ff @(posedge i_mclk) begin
    if (i_reset) begin
      r_q     <= RESET_VAL;
      r_q_n   <= ~RESET_VAL;
      r_clk_f <= i_clk;
      r_cnt   <= '0;
      r_d_s   <= '0;
      r_s_s   <= '0;
      r_sr_s  <= 1'b0;
      r_sl_s  <= 1'b0;
    end else begin
      r_d_s  <= i_d;
      r_s_s  <= i_s;
      r_sr_s <= i_sr_in;
      r_sl_s <= i_sl_in;

      if (i_clk == r_clk_f) begin
        r_cnt <= '0;
      end else if (r_cnt == FILT) begin
        r_clk_f <= i_clk;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Shift sources come from pre-update r_q, so a forced bit still feeds its neighbour.
      for (int i = 0; i < WIDTH; i++) begin
        if (!i_pre_n[i] && !i_clr_n[i]) begin
          r_q[i]   <= 1'b1;
          r_q_n[i] <= 1'b1;
        end else if (!i_pre_n[i]) begin
          r_q[i]   <= 1'b1;
          r_q_n[i] <= 1'b0;
        end else if (!i_clr_n[i]) begin
          r_q[i]   <= 1'b0;
          r_q_n[i] <= 1'b1;
        end else if (w_edge) begin
          r_q[i]   <= w_next[i];
          r_q_n[i] <= ~w_next[i];
        end
      end
    end
  end

  assign o_q   = r_q;
  assign o_q_n = r_q_n;

endmodule

// File: tb/tb_ttl_univ_reg.sv
// tb/tb_ttl_univ_reg.sv - directed-vector bench for ttl_univ_reg (FILTER=0 and FILTER=2 instances)
module tb_ttl_univ_reg;

  logic       mclk;
  logic       reset;
  logic       clk;
  logic       clk2;
  logic [1:0] s;
  logic [3:0] d;
  logic       sr_in;
  logic       sl_in;
  logic [3:0] pre_n;
  logic [3:0] clr_n;
  logic [3:0] ones;
  logic [3:0] q;
  logic [3:0] q_n;
  logic [3:0] q2;
  logic [3:0] q2_n;

  int n_vec;
  int n_err;

  ttl_univ_reg #(.WIDTH(4), .FILTER(0), .EDGE(1), .RESET_VAL(4'hA)) u_dut (
    .i_mclk(mclk), .i_reset(reset), .i_clk(clk), .i_s(s), .i_d(d),
    .i_sr_in(sr_in), .i_sl_in(sl_in), .i_pre_n(pre_n), .i_clr_n(clr_n),
    .o_q(q), .o_q_n(q_n)
  );

  ttl_univ_reg #(.WIDTH(4), .FILTER(2), .EDGE(1), .RESET_VAL(4'hA)) u_flt (
    .i_mclk(mclk), .i_reset(reset), .i_clk(clk2), .i_s(s), .i_d(d),
    .i_sr_in(sr_in), .i_sl_in(sl_in), .i_pre_n(ones), .i_clr_n(ones),
    .o_q(q2), .o_q_n(q2_n)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge mclk);
      #1;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; clk = 1'b0; clk2 = 1'b0; s = 2'b00; d = 4'h0;
    sr_in = 1'b0; sl_in = 1'b0; pre_n = 4'hF; clr_n = 4'hF; ones = 4'hF;
    tick(2);
    reset = 1'b0;
    check("reset_q", q, 4'hA);
    check("reset_qn", q_n, 4'h5);
    check("reset_q_flt", q2, 4'hA);

    // parallel load on rising edge, nothing on falling edge
    d = 4'h3; s = 2'b11; tick();
    clk = 1'b1; tick();
    check("load_q", q, 4'h3);
    check("load_qn", q_n, 4'hC);
    clk = 1'b0; tick();
    check("fall_noact", q, 4'h3);

    s = 2'b01; sr_in = 1'b1; tick();
    clk = 1'b1; tick();
    check("shr_q", q, 4'h7);
    clk = 1'b0; tick();

    s = 2'b10; sl_in = 1'b0; tick();
    clk = 1'b1; tick();
    check("shl_q", q, 4'h3);
    clk = 1'b0; tick();

    s = 2'b00; tick();
    clk = 1'b1; tick();
    check("hold_q", q, 4'h3);
    check("hold_qn", q_n, 4'hC);
    clk = 1'b0; tick();

    // data changing with the edge is not yet sampled
    s = 2'b11; d = 4'h5; tick();
    d = 4'h6; clk = 1'b1; tick();
    check("setup_q", q, 4'h5);
    clk = 1'b0; tick();
    clk = 1'b1; tick();
    check("setup_next_q", q, 4'h6);
    clk = 1'b0; tick();

    // both-low on bit 0 gives 1/1, persisting after release until an edge
    pre_n = 4'hE; clr_n = 4'hE; tick();
    check("bothlow_q", q, 4'h7);
    check("bothlow_qn", q_n, 4'h9);
    pre_n = 4'hF; clr_n = 4'hF; tick();
    check("release_q", q, 4'h7);
    check("release_qn", q_n, 4'h9);
    d = 4'h0; tick();
    clk = 1'b1; tick();
    check("restore_q", q, 4'h0);
    check("restore_qn", q_n, 4'hF);
    clk = 1'b0; tick();

    // clear bit 3 during shift right of F
    d = 4'hF; tick();
    clk = 1'b1; tick();
    check("loadF_q", q, 4'hF);
    clk = 1'b0; s = 2'b01; sr_in = 1'b1; tick();
    clr_n = 4'h7; clk = 1'b1; tick();
    check("clr3_shr_q", q, 4'h7);
    check("clr3_shr_qn", q_n, 4'h8);
    clr_n = 4'hF; clk = 1'b0; tick();

    // cleared bit 0 still feeds bit 1 its pre-update value
    sr_in = 1'b0; tick();
    clr_n = 4'hE; clk = 1'b1; tick();
    check("clr0_nbr_q", q, 4'hE);
    check("clr0_nbr_qn", q_n, 4'h1);
    clr_n = 4'hF; clk = 1'b0; tick();

    // deglitch filter, FILTER=2
    s = 2'b11; d = 4'h9; tick();
    clk2 = 1'b1; tick();
    clk2 = 1'b0; tick();
    check("flt_glitch1", q2, 4'hA);
    clk2 = 1'b1; tick(2);
    clk2 = 1'b0; tick();
    check("flt_glitch2", q2, 4'hA);
    check("flt_dut0_idle", q, 4'hE);
    clk2 = 1'b1; tick(2);
    check("flt_pending", q2, 4'hA);
    tick();
    check("flt_accept", q2, 4'h9);
    check("flt_accept_qn", q2_n, 4'h6);
    clk2 = 1'b0; tick(3);
    check("flt_fall", q2, 4'h9);

    // reset beats preset and edge; release with clk high gives no edge
    d = 4'hC; reset = 1'b1; pre_n = 4'h0; clk = 1'b1; tick();
    check("rst_prio_q", q, 4'hA);
    check("rst_prio_qn", q_n, 4'h5);
    reset = 1'b0; pre_n = 4'hF; tick();
    check("rst_rel_q", q, 4'hA);
    clk = 1'b0; tick();
    clk = 1'b1; tick();
    check("post_rst_q", q, 4'hC);
    check("post_rst_qn", q_n, 4'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
